sha256_wk_sched: RTL and testbench
==================================

# sha256_wk_sched

Message-schedule engine for the SHA-256 datapath. It accepts one 512-bit message block, expands it into the 64 schedule words W[0..63], and streams one round-constant-combined word per cycle. That word is W[t]+K[t], the `agwk`-side operand consumed by the `efgh` round slice. It is the producer end of the `efgh` operand interface: `efgh` consumes one word per round, and this block generates it in round order with flow control.

## Interface
Parameters:
- `ROUNDS`, default 64: number of words emitted per block. Fixed at 64 for SHA-256 and must not be overridden.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `blk_valid`  in  1  `blk_data` holds a block.
- `blk_ready`  out  1  block accepted this cycle when high with `blk_valid`.
- `blk_data`  in  512  message block, big-endian; M[0] = [511:480], M[15] = [31:0].
- `wk_valid`  out  1  `wk`, `wk_round` and `wk_last` are valid.
- `wk_ready`  in  1  downstream consumes the word this cycle.
- `wk`  out  32  W[t]+K[t] mod 2^32 (see Configuration).
- `wk_round`  out  6  t of the current word.
- `wk_last`  out  1  high with t = 63.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `blk_ready` = 1, `wk_valid` = 0.
  - On `blk_valid & blk_ready`: load M[0..15] into the 16-word window, set t = 0, go to RUN.
- RUN:
  - `blk_ready` = 0. `blk_valid` is ignored.
  - `wk_valid` = 1.
  - Output word = window[0] + K[t].
- Accept handshake (`wk_valid & wk_ready`): shift the window down one word, append W[t+16], increment t.
  - W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t], all mod 2^32.
  - σ0(x) = rotr7 ^ rotr18 ^ shr3.
  - σ1(x) = rotr17 ^ rotr19 ^ shr10.
- Once t ≥ 48, expansion values are computed but never emitted; this is harmless.
- Accept at t = 63: go to IDLE.
- Stall (`wk_valid & !wk_ready`): `wk`, `wk_round`, `wk_last` and the window hold exactly.
- Back-to-back blocks are not supported; there is one IDLE cycle minimum between blocks.
- Reset values:
  - state = IDLE.
  - `wk_valid` = 0, `wk` = 0, `wk_round` = 0, `wk_last` = 0.
  - window cleared to 0.
  - `blk_ready` = 0 while `rst` is high, 1 on the first cycle after release.
- `rst` during RUN: the in-flight block is abandoned, nothing further is emitted, and the block returns to IDLE next cycle.

## Timing
- Block accepted at edge N: first word (t = 0) has `wk_valid` = 1 after edge N+1.
- Throughput: one word per cycle with `wk_ready` held high; a block's 64 words occupy edges N+1..N+64.
- `blk_ready` high again after edge N+65, so the minimum block period is 65 cycles.
- All outputs are registered. `blk_ready` decodes state and `rst` only; it has no combinational path from any input other than `rst`.
- The next W and the W+K sum are each one 32-bit add chain, computed from registers into registers.

## Configuration
- `WK_SCHED_KADD_EN` defined:
  - `wk` = W[t]+K[t].
  - The K table and its adder are instantiated.
- Not defined:
  - `wk` = W[t] raw; the consumer adds K[t].
  - No K ROM or adder is present.
  - Handshake, latency and all other outputs are identical.

## Structure
- Shared package `sha256_pkg` holds:
  - the 64-entry K constant array;
  - `sigma0`/`sigma1` functions;
  - localparam `SHA256_ROUNDS` = 64;
  - typedef `word_t` (32-bit).
- One sub-module `sha256_wexp`: combinational W[t+16] from four window taps.
- The FSM and window stay in the top module.

## Test plan
1. "abc" padded block (M[0] = 0x61626380, M[15] = 0x00000018, rest 0) with `wk_ready` = 1, macro defined. Required words:
   - t0 `wk` = 0xa3ec9318;
   - t15 = 0xc19bf18c;
   - t16 = 0x45fdcd41;
   - t17 = 0xefcd4786;
   - 64 words total;
   - `wk_last` only with t = 63.
2. Same block, macro undefined:
   - t0 = 0x61626380;
   - t16 = 0x61626380;
   - t17 = 0x000f0000.
3. All-zero block:
   - every `wk` = K[t];
   - t = 63 gives 0xc67178f2;
   - `blk_ready` returns exactly 65 cycles after acceptance.
4. Random `wk_ready` pattern on the "abc" block: output sequence identical to test 1, and `wk` is stable during every stalled cycle.
5. `blk_valid` held high with a different block during RUN: ignored. The second block is accepted only in IDLE, and its t0 word appears after the first block's t = 63.
6. `rst` pulsed for one cycle at t = 20:
   - next cycle `wk_valid` = 0, state IDLE, `blk_ready` = 1;
   - a new "abc" block then yields t0 = 0xa3ec9318.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, round count, K constants and schedule sigmas.
// Pure declarations and functions, no state.
package sha256_pkg;

    localparam int SHA256_ROUNDS = 64;

    typedef logic [31:0] word_t;

    typedef enum logic {IDLE, RUN} wk_state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_wexp.sv
// Combinational schedule expansion: W[t+16] from window taps W[t], W[t+1], W[t+9], W[t+14].
// Zero latency, no flow control.
module sha256_wexp
    import sha256_pkg::*;
(
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w9_i,
    input  logic [31:0] w14_i,
    output logic [31:0] w16_o
);

    assign w16_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_wk_sched.sv
// SHA-256 message schedule: one 512-bit block in, 64 words W[t](+K[t] when WK_SCHED_KADD_EN) out.
// First word one cycle after block accept; valid/ready output, stalls hold word and window.
module sha256_wk_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         wk_valid,
    input  logic         wk_ready,
    output logic [31:0]  wk,
    output logic [5:0]   wk_round,
    output logic         wk_last
);

    wk_state_t   state_q;
    word_t       win_q [16];
    logic [5:0]  t_q;
    logic        wk_valid_q;
    word_t       wk_q;
    logic [5:0]  wk_round_q;
    logic        wk_last_q;

    word_t       w16_d;
    word_t       wk_d;
    logic        done;
    logic        issue;

    sha256_wexp u_wexp (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .w16_o (w16_d)
    );

`ifdef WK_SCHED_KADD_EN
    assign wk_d = win_q[0] + K[t_q];
`else
    assign wk_d = win_q[0];
`endif

    // The word register is loaded on entry to RUN (empty) and on every accept.
    assign done  = wk_valid_q & wk_ready & wk_last_q;
    assign issue = (state_q == RUN) & ~done & (~wk_valid_q | wk_ready);

    assign blk_ready = (state_q == IDLE) & ~rst;
    assign wk_valid  = wk_valid_q;
    assign wk        = wk_q;
    assign wk_round  = wk_round_q;
    assign wk_last   = wk_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            t_q        <= '0;
            wk_valid_q <= 1'b0;
            wk_q       <= '0;
            wk_round_q <= '0;
            wk_last_q  <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) win_q[i] <= blk_data[511 - 32*i -: 32];
                        t_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (done) begin
                        state_q    <= IDLE;
                        wk_valid_q <= 1'b0;
                        wk_last_q  <= 1'b0;
                    end else if (issue) begin
                        wk_q       <= wk_d;
                        wk_round_q <= t_q;
                        wk_last_q  <= (t_q == 6'(ROUNDS - 1));
                        wk_valid_q <= 1'b1;
                        t_q        <= t_q + 6'd1;
                        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
                        win_q[15]  <= w16_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_wk_sched.sv
// Directed + randomized bench for sha256_wk_sched against an arithmetic SHA-256 schedule model.
module tb_sha256_wk_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         wk_valid;
    logic         wk_ready;
    logic [31:0]  wk;
    logic [5:0]   wk_round;
    logic         wk_last;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [64];
    logic [31:0] obs_w [64];

    localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_wk_sched dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .wk_valid  (wk_valid),
        .wk_ready  (wk_ready),
        .wk        (wk),
        .wk_round  (wk_round),
        .wk_last   (wk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_ref(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) begin
`ifdef WK_SCHED_KADD_EN
            exp_q[i] = w[i] + TK[i];
`else
            exp_q[i] = w[i];
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_block(input logic [511:0] blk, input bit hold, input logic [511:0] nxt);
        int i = 0;
        while (blk_ready !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("blk_ready_wait", 64'(blk_ready), 64'd1);
        blk_valid = 1'b1;
        blk_data  = blk;
        @(negedge clk);
        if (hold) begin
            blk_data = nxt;
        end else begin
            blk_valid = 1'b0;
            blk_data  = '0;
        end
        chk("after_accept", {62'd0, blk_ready, wk_valid}, 64'd0);
    endtask

    task automatic collect(input bit rnd, input bit timed);
        int k = 0;
        int n = 0;
        int stall_err = 0;
        int rdy_err = 0;
        int first_k = -1;
        bit prev_stall = 1'b0;
        bit got_last = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pr = '0;
        logic        pl = 1'b0;
        for (int i = 0; i < 64; i++) obs_w[i] = 'x;
        while (!got_last && k < 2000) begin
            if (wk_valid === 1'b1 && first_k < 0) first_k = k;
            if (prev_stall && !(wk_valid === 1'b1 && wk === pw && wk_round === pr && wk_last === pl))
                stall_err++;
            if (blk_ready !== 1'b0) rdy_err++;
            wk_ready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_stall = (wk_valid === 1'b1) && !wk_ready;
            pw = wk;
            pr = wk_round;
            pl = wk_last;
            if (wk_valid === 1'b1 && wk_ready) begin
                if (n < 64) begin
                    obs_w[n] = wk;
                    chk($sformatf("word%0d", n), {25'd0, wk_last, wk_round, wk},
                        {25'd0, n == 63, 6'(n), exp_q[n]});
                end
                n++;
                got_last = (wk_last === 1'b1);
            end
            @(negedge clk);
            k++;
        end
        wk_ready = 1'b0;
        chk("word_count", 64'(n), 64'd64);
        chk("first_latency", 64'(first_k), 64'd1);
        chk("stall_hold", 64'(stall_err), 64'd0);
        chk("blk_ready_in_run", 64'(rdy_err), 64'd0);
        chk("idle_after_last", {62'd0, blk_ready, wk_valid}, 64'b10);
        if (timed) chk("block_period", 64'(k), 64'd65);
    endtask

    initial begin
        logic [511:0] rblk;
        int i;

        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        wk_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {23'd0, blk_ready, wk_valid, wk_last, wk_round, wk}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(blk_ready), 64'd1);

        // "abc" block, continuous ready
        build_ref(ABC);
        start_block(ABC, 1'b0, '0);
        collect(1'b0, 1'b1);
`ifdef WK_SCHED_KADD_EN
        chk("abc_t0",  64'(obs_w[0]),  64'h a3ec9318);
        chk("abc_t15", 64'(obs_w[15]), 64'h c19bf18c);
        chk("abc_t16", 64'(obs_w[16]), 64'h 45fdcd41);
        chk("abc_t17", 64'(obs_w[17]), 64'h efcd4786);
`else
        chk("abc_t0",  64'(obs_w[0]),  64'h 61626380);
        chk("abc_t15", 64'(obs_w[15]), 64'h 00000018);
        chk("abc_t16", 64'(obs_w[16]), 64'h 61626380);
        chk("abc_t17", 64'(obs_w[17]), 64'h 000f0000);
`endif

        // all-zero block, also checks the 65-cycle block period
        build_ref('0);
        start_block('0, 1'b0, '0);
        collect(1'b0, 1'b1);
`ifdef WK_SCHED_KADD_EN
        chk("zero_t63", 64'(obs_w[63]), 64'h c67178f2);
`else
        chk("zero_t63", 64'(obs_w[63]), 64'h 0);
`endif

        // "abc" block under random backpressure
        build_ref(ABC);
        start_block(ABC, 1'b0, '0);
        collect(1'b1, 1'b0);

        // random block with a second block held on the input during RUN
        for (int j = 0; j < 16; j++) rblk[511 - 32*j -: 32] = $urandom();
        build_ref(rblk);
        start_block(rblk, 1'b1, ABC);
        collect(1'b0, 1'b1);
        build_ref(ABC);
        start_block(ABC, 1'b0, '0);
        collect(1'b1, 1'b0);

        // reset mid-block at t = 20, then a fresh block
        build_ref(ABC);
        start_block(ABC, 1'b0, '0);
        wk_ready = 1'b1;
        i = 0;
        while (!(wk_valid === 1'b1 && wk_round === 6'd20) && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("reach_t20", 64'(wk_round), 64'd20);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        wk_ready = 1'b0;
        #1;
        chk("rst_mid_run", {23'd0, blk_ready, wk_valid, wk_last, wk_round, wk}, {23'd0, 1'b1, 40'd0});
        start_block(ABC, 1'b0, '0);
        collect(1'b0, 1'b1);
`ifdef WK_SCHED_KADD_EN
        chk("post_rst_t0", 64'(obs_w[0]), 64'h a3ec9318);
`else
        chk("post_rst_t0", 64'(obs_w[0]), 64'h 61626380);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
